// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and
// the width helper used to size the source-ID field.
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_e;

   // Ceiling log2, usable in constant (parameter) expressions.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: returns a one-hot grant for the first
// set request at or above i_ptr, wrapping to the lowest set request.
module rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned PTR_W = clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N-1:0]     o_gnt
);

   logic [N-1:0]   w_mask;
   logic [2*N-1:0] w_dbl;
   logic [2*N-1:0] w_pick;

   always_comb begin
      w_mask = '0;
      for (int unsigned i = 0; i < N; i++) begin
         w_mask[i] = (PTR_W'(i) >= i_ptr);
      end
   end

   // Low half holds requests at/above the pointer, high half the full vector;
   // the lowest set bit of the double-width word is the wrapped winner.
   assign w_dbl  = {i_req, i_req & w_mask};
   assign w_pick = w_dbl & (~w_dbl + (2*N)'(1));
   assign o_gnt  = w_pick[N-1:0] | w_pick[2*N-1:N];

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin packet arbiter in front of a FIFO write port. The granted
// producer owns the port until its last beat, and each word carries its ID.
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned N_REQ      = 4,
   parameter  int unsigned DATA_WIDTH = 8,
   localparam int unsigned ID_W       = clog2(N_REQ)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ-1:0]            req_last,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            req_ready,
   output logic [N_REQ-1:0]            grant,
   output logic                        busy,
   output logic [ID_W+DATA_WIDTH-1:0]  fifo_din,
   output logic                        fifo_wr_en,
   input  logic                        fifo_full
);

   arb_state_e            r_state, w_state_nxt;
   logic [ID_W-1:0]       r_owner, w_owner_nxt;
   logic [ID_W-1:0]       r_rr_ptr, w_rr_ptr_nxt;
   logic [N_REQ-1:0]      r_grant, w_grant_nxt;
   logic [N_REQ-1:0]      w_pick;
   logic [ID_W-1:0]       w_pick_idx;
   logic                  w_owner_valid;
   logic                  w_owner_last;
   logic [DATA_WIDTH-1:0] w_owner_data;

   rr_arbiter #(
      .N     (N_REQ),
      .PTR_W (ID_W)
   ) u_rr_arbiter (
      .i_req (req_valid),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_pick)
   );

   always_comb begin
      w_pick_idx    = '0;
      w_owner_valid = 1'b0;
      w_owner_last  = 1'b0;
      w_owner_data  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (w_pick[i]) w_pick_idx = ID_W'(i);
         if (ID_W'(i) == r_owner) begin
            w_owner_valid = req_valid[i];
            w_owner_last  = req_last[i];
            w_owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign busy  = (r_state == ST_LOCK);
   assign grant = r_grant;

   // Ready depends only on registered ownership and fifo_full, never on valid.
   always_comb begin
      req_ready  = '0;
      fifo_wr_en = 1'b0;
      fifo_din   = '0;
      if (busy) begin
         req_ready  = r_grant & {N_REQ{~fifo_full}};
         fifo_wr_en = w_owner_valid & ~fifo_full;
         fifo_din   = {r_owner, w_owner_data};
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_rr_ptr_nxt = r_rr_ptr;
      w_grant_nxt  = r_grant;
      case (r_state)
         ST_IDLE: begin
            if ((|req_valid) && !fifo_full) begin
               w_state_nxt = ST_LOCK;
               w_owner_nxt = w_pick_idx;
               w_grant_nxt = w_pick;
            end
         end
         ST_LOCK: begin
            if (fifo_wr_en && w_owner_last) begin
               w_state_nxt  = ST_IDLE;
               w_grant_nxt  = '0;
               w_rr_ptr_nxt = (r_owner == ID_W'(N_REQ - 1)) ? '0 : r_owner + ID_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_owner  <= '0;
         r_rr_ptr <= '0;
         r_grant  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_owner  <= w_owner_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
         r_grant  <= w_grant_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: fixed vector table, directed corner sequences and
// random traffic checked cycle by cycle against a packet-level model.
module tb_fifo_wr_arb;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_last = '0;
   logic [N*DW-1:0]   req_data = '0;
   logic              fifo_full = 1'b0;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      grant;
   logic              busy;
   logic [IW+DW-1:0]  fifo_din;
   logic              fifo_wr_en;

   always #5 clk = ~clk;

   fifo_wr_arb #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_last   (req_last),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .grant      (grant),
      .busy       (busy),
      .fifo_din   (fifo_din),
      .fifo_wr_en (fifo_wr_en),
      .fifo_full  (fifo_full)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int m_owner = -1;
   int m_rr    = 0;
   int cyc     = 0;
   logic [N-1:0]     m_acc = '0;
   logic [IW+DW-1:0] wlog[$];
   int               wcyc[$];

   typedef struct {
      logic [N-1:0]     v;
      logic [N-1:0]     l;
      logic             f;
      logic [31:0]      d;
      logic [N-1:0]     g;
      logic [N-1:0]     r;
      logic             w;
      logic [IW+DW-1:0] din;
   } vec_t;
   vec_t tbl[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Packet-level model: an owner index (or none) and a rotating start point.
   task automatic model_check();
      logic [N-1:0]     eg, er;
      logic             ew;
      logic [IW+DW-1:0] ed;
      eg = '0; er = '0; ew = 1'b0; ed = '0;
      if (m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         er[m_owner] = !fifo_full;
         ew = req_valid[m_owner] && !fifo_full;
         ed = {IW'(m_owner), req_data[m_owner*DW +: DW]};
      end
      check("grant",   32'(grant),      32'(eg));
      check("busy",    32'(busy),       32'(m_owner >= 0));
      check("ready",   32'(req_ready),  32'(er));
      check("wr_en",   32'(fifo_wr_en), 32'(ew));
      check("din",     32'(fifo_din),   32'(ed));
      m_acc = ew ? eg : '0;
   endtask

   task automatic model_update();
      bit found;
      found = 0;
      if (m_owner < 0) begin
         if ((|req_valid) && !fifo_full) begin
            for (int k = 0; k < N; k++) begin
               if (!found && req_valid[(m_rr + k) % N]) begin
                  m_owner = (m_rr + k) % N;
                  found = 1;
               end
            end
         end
      end else if (m_acc != '0 && req_last[m_owner]) begin
         m_rr    = (m_owner + 1) % N;
         m_owner = -1;
      end
   endtask

   task automatic sample();
      @(negedge clk);
      model_check();
      if (fifo_wr_en) begin
         wlog.push_back(fifo_din);
         wcyc.push_back(cyc);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic cycle();
      sample();
      advance();
   endtask

   task automatic reset_dut();
      #2 rst_n = 1'b0;
      m_owner = -1;
      m_rr    = 0;
      #4 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, stall, ok;
      int left[N];
      int bc[N];

      tbl[0] = '{4'b0100, 4'b0000, 1'b0, 32'h00A0_0000, 4'b0000, 4'b0000, 1'b0, 10'h000};
      tbl[1] = '{4'b0100, 4'b0000, 1'b0, 32'h00A0_0000, 4'b0100, 4'b0100, 1'b1, 10'h2A0};
      tbl[2] = '{4'b0100, 4'b0000, 1'b0, 32'h00A1_0000, 4'b0100, 4'b0100, 1'b1, 10'h2A1};
      tbl[3] = '{4'b0100, 4'b0100, 1'b0, 32'h00A2_0000, 4'b0100, 4'b0100, 1'b1, 10'h2A2};
      tbl[4] = '{4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 10'h000};
      tbl[5] = '{4'b1000, 4'b0000, 1'b1, 32'h5D00_0000, 4'b0000, 4'b0000, 1'b0, 10'h000};
      tbl[6] = '{4'b1000, 4'b0000, 1'b0, 32'h5D00_0000, 4'b0000, 4'b0000, 1'b0, 10'h000};
      tbl[7] = '{4'b1000, 4'b1000, 1'b0, 32'h5D00_0000, 4'b1000, 4'b1000, 1'b1, 10'h35D};
      tbl[8] = '{4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 1'b0, 10'h000};

      // Outputs while reset is held
      #2;
      check("rst_grant", 32'(grant),      32'd0);
      check("rst_busy",  32'(busy),       32'd0);
      check("rst_ready", 32'(req_ready),  32'd0);
      check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      check("rst_din",   32'(fifo_din),   32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Vector table: 3-beat packet from req 2, then full-while-idle on req 3
      for (int i = 0; i < 9; i++) begin
         req_valid = tbl[i].v;
         req_last  = tbl[i].l;
         fifo_full = tbl[i].f;
         req_data  = tbl[i].d;
         sample();
         check($sformatf("tbl%0d_grant", i), 32'(grant),      32'(tbl[i].g));
         check($sformatf("tbl%0d_ready", i), 32'(req_ready),  32'(tbl[i].r));
         check($sformatf("tbl%0d_wr",    i), 32'(fifo_wr_en), 32'(tbl[i].w));
         check($sformatf("tbl%0d_din",   i), 32'(fifo_din),   32'(tbl[i].din));
         advance();
      end

      // Fairness: all requesters continuously valid with 2-beat packets
      reset_dut();
      wlog.delete(); wcyc.delete();
      for (int i = 0; i < N; i++) bc[i] = 0;
      req_valid = '1;
      for (int t = 0; t < 60 && wlog.size() < 10; t++) begin
         for (int i = 0; i < N; i++) begin
            req_last[i] = (bc[i] == 1);
            req_data[i*DW +: DW] = DW'(16 * i + bc[i]);
         end
         cycle();
         for (int i = 0; i < N; i++) if (m_acc[i]) bc[i] = (bc[i] + 1) % 2;
      end
      req_valid = '0;
      req_last  = '0;
      if (wlog.size() < 10) begin
         check("fair_count", 32'(wlog.size()), 32'd10);
      end else begin
         for (int j = 0; j < 10; j++) begin
            check($sformatf("fair_id%0d", j), 32'(wlog[j][IW+DW-1:DW]), 32'((j / 2) % N));
         end
         check("fair_span", 32'(wcyc[9] - wcyc[0]), 32'd13);
      end

      // FIFO full on beat 2 for 3 cycles
      reset_dut();
      wlog.delete(); wcyc.delete();
      b = 0; stall = 0;
      req_valid = 4'b0001;
      req_data  = 32'h0000_00B0;
      cycle();
      for (int t = 0; t < 20 && b < 4; t++) begin
         fifo_full = (b == 1 && stall < 3);
         req_data[DW-1:0] = DW'(8'hB0 + b);
         req_last[0] = (b == 3);
         sample();
         if (fifo_full) begin
            check("stall_ready", 32'(req_ready),  32'd0);
            check("stall_wr",    32'(fifo_wr_en), 32'd0);
            check("stall_grant", 32'(grant),      32'b0001);
            stall++;
         end
         advance();
         if (m_acc[0]) b++;
      end
      req_valid = '0; req_last = '0; fifo_full = 1'b0;
      check("stall_beats", 32'(wlog.size()), 32'd4);
      if (wlog.size() == 4) begin
         for (int j = 0; j < 4; j++) check($sformatf("stall_word%0d", j), 32'(wlog[j]), 32'(8'hB0 + j));
      end

      // No interleave: req 0 asks while req 1 is mid-packet
      reset_dut();
      b = 0; ok = 1;
      req_valid = 4'b0010;
      cycle();
      for (int t = 0; t < 20 && b < 4; t++) begin
         req_data[2*DW-1:DW] = DW'(8'hC0 + b);
         req_last[1] = (b == 3);
         if (b >= 2) begin
            req_valid[0] = 1'b1;
            req_last[0]  = 1'b1;
            req_data[DW-1:0] = 8'hE0;
         end
         sample();
         if (b >= 2) check("noint_ready0", 32'(req_ready[0]), 32'd0);
         advance();
         if (m_acc[1]) b++;
      end
      check("noint_beats", 32'(b), 32'd4);
      req_valid[1] = 1'b0;
      req_last[1]  = 1'b0;
      cycle();
      check("noint_next_grant", 32'(grant), 32'b0001);
      cycle();
      req_valid = '0; req_last = '0;
      cycle();

      // Reset mid-packet, then rr_ptr must be back at 0
      reset_dut();
      req_valid = 4'b0010; req_last = 4'b0010;
      cycle(); cycle();
      req_valid = '0; req_last = '0;
      cycle();
      req_valid = 4'b0100;
      cycle(); cycle();
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_grant", 32'(grant),      32'd0);
      check("arst_busy",  32'(busy),       32'd0);
      check("arst_wr_en", 32'(fifo_wr_en), 32'd0);
      m_owner = -1;
      m_rr    = 0;
      req_valid = 4'b1010;
      #2 rst_n = 1'b1;
      advance();
      check("post_rst_grant", 32'(grant), 32'b0010);
      req_valid = '0;
      cycle(); cycle();

      // Random traffic against the model
      reset_dut();
      for (int i = 0; i < N; i++) left[i] = 0;
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < N; i++) begin
            if (m_acc[i]) begin
               left[i]--;
               if (left[i] == 0) begin
                  req_valid[i] = 1'b0;
               end else begin
                  req_valid[i] = ($urandom % 4) != 0;
                  req_data[i*DW +: DW] = DW'($urandom);
               end
            end else if (!req_valid[i]) begin
               if (left[i] > 0) begin
                  req_valid[i] = $urandom % 2 == 1;
               end else if ($urandom % 3 == 0) begin
                  left[i] = 1 + int'($urandom % 4);
                  req_valid[i] = 1'b1;
                  req_data[i*DW +: DW] = DW'($urandom);
               end
            end
            req_last[i] = (left[i] == 1);
         end
         fifo_full = ($urandom % 4) == 0;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write arbiter that shares one synchronous FIFO write port between `N_REQ` packet producers. Each producer uses a valid/ready stream with a `last` marker. A granted producer keeps the FIFO until its packet ends, so packets are never interleaved. Every FIFO word carries its source ID, so the consumer can demultiplex. The block sits directly in front of the FIFO write side (`din`/`wr_en`/`full`) and holds no data storage of its own.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 8: payload width per beat.
- `ID_W`, derived as clog2(`N_REQ`): source-ID width. Not overridable.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  `N_REQ`  per-requester beat valid.
- `req_last`  in  `N_REQ`  per-requester last-beat-of-packet flag.
- `req_data`  in  `N_REQ`*`DATA_WIDTH`  packed payloads; requester i occupies bits [i*`DATA_WIDTH` +: `DATA_WIDTH`].
- `req_ready`  out  `N_REQ`  per-requester beat accept.
- `grant`  out  `N_REQ`  one-hot current owner, registered.
- `busy`  out  1  high while in LOCK.
- `fifo_din`  out  `ID_W`+`DATA_WIDTH`  {owner ID, owner data}.
- `fifo_wr_en`  out  1  FIFO write strobe.
- `fifo_full`  in  1  FIFO full, combinational from FIFO pointers.

## Operation
- FSM has two states, IDLE and LOCK. Reset state: IDLE, `grant`=0, round-robin pointer `rr_ptr`=0.
- In IDLE with any `req_valid` high and `fifo_full` low:
  - pick the first requester with valid set, searching from `rr_ptr` upward and wrapping modulo `N_REQ`;
  - register it as owner, drive `grant` one-hot, go to LOCK.
- In IDLE with no valid, or with `fifo_full` high: stay in IDLE, `grant`=0.
- In LOCK:
  - `req_ready[owner]` = ~`fifo_full`; all other ready bits are 0.
  - `fifo_wr_en` = `req_valid[owner]` & `req_ready[owner]`.
  - `fifo_din` = {owner index, `req_data[owner]`}.
- On an accepted beat with `req_last[owner]`=1: set `rr_ptr` = (owner+1) mod `N_REQ`, clear `grant`, return to IDLE.
- `fifo_full` high mid-packet: stall. Ownership is held, ready drops, no write.
- Owner drops valid mid-packet: ownership is held with no timeout and no write.
- `req_valid` in IDLE is only a request; no beat is accepted in IDLE (ready = 0 for all requesters).
- Requesters must hold `data`/`last` stable while valid is high and ready is low.
- Single-beat packet (valid and last both high on the first beat) is legal.
- Out of reset, all outputs are 0: `req_ready`, `grant`, `busy`, `fifo_wr_en`, `fifo_din`.
- Reset asserted mid-packet: immediate return to IDLE, outputs cleared. The partial packet already written remains in the FIFO; the FIFO must share `rst_n`.

## Timing
- Arbitration latency: valid seen at edge k → `grant`/`busy` high after edge k. The first beat can be accepted at edge k+1, i.e. written into the FIFO on that edge.
- Throughput is one beat per cycle inside a packet.
- Exactly one IDLE cycle between consecutive packets, including back-to-back packets from the same requester.
- `req_ready`, `fifo_wr_en` and `fifo_din` are combinational from registered state and `fifo_full`. There is no combinational path from `req_valid` to `req_ready`.
- Fairness: with all requesters continuously valid, the grant order is 0,1,2,3,0,…
- `rr_ptr` advances only on packet completion, never on grant.

## Structure
- Shared package `fifo_arb_pkg`: state encoding (IDLE=0, LOCK=1) and the clog2 helper function used for `ID_W`.
- Sub-module `rr_arbiter`: combinational one-hot round-robin pick from a request vector and start pointer, implemented as a double-width mask-and-priority scheme.
- Top level contains: FSM, owner register, `rr_ptr`, output muxes.
- The FIFO itself is instantiated outside this block.

## Test plan
- Single requester: req 2 sends a 3-beat packet A0,A1,A2 → `fifo_din` = {2,A0},{2,A1},{2,A2} on three consecutive edges; `grant`=4'b0100 for 3 cycles, then IDLE.
- All four requesters continuously valid with 2-beat packets → source ID sequence 0,0,1,1,2,2,3,3,0,0; exactly one idle cycle between packets.
- No interleave: req 1 is mid-packet (beat 2 of 4) and req 0 raises valid → req 0 stays ready=0 until req 1's last beat is accepted; req 0 wins next because `rr_ptr`=2 wraps 2→3→0 and req 3 is idle.
- FIFO full on beat 2 for 3 cycles → ready and `fifo_wr_en` low for 3 cycles, `grant` held, beat 2 written on the cycle `fifo_full` falls; no beat lost or duplicated.
- `fifo_full` high while IDLE with req 3 valid → no grant until full drops, then `grant`=4'b1000 after one edge.
- `rst_n` pulsed low mid-packet → `grant`, `busy`, `fifo_wr_en` go 0 asynchronously; after release, the first grant goes to the lowest-index valid requester (`rr_ptr`=0).
